// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch-side PC register and redirect controller.
// Validates incoming jump/branch targets against their source PC, recovers the
// J-type instr_index, and drives the fetch PC to instruction memory.
// Optional feature macro: PC_REDIRECT_DELAY_SLOT_EN
//   defined   -> accepted redirects pass through one architectural delay slot
//   undefined -> accepted redirects load the target on the next cycle
module pc_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   output logic        redirect_ready,
   input  logic [31:0] redirect_target,
   input  logic        redirect_is_j,
   input  logic [31:0] redirect_src_pc,
   output logic [31:0] fetch_pc,
   output logic        fetch_valid,
   output logic [25:0] jidx,
   output logic        err_misalign,
   output logic        err_region
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      SLOT = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] src_plus4;
   logic        bad_align;
   logic        bad_region;

`ifdef PC_REDIRECT_DELAY_SLOT_EN
   logic [31:0] pending_target;
`endif

   // Validation of the incoming request; the J-type region is the top nibble
   // of the instruction after the jump (src_pc+4, 32-bit wrap).
   always_comb begin
      src_plus4  = redirect_src_pc + 32'd4;
      bad_align  = (redirect_target[1:0] != 2'b00);
      bad_region = redirect_is_j &&
                   (((redirect_target ^ src_plus4) & 32'hF000_0000) != '0);
   end

   assign redirect_ready = (state == RUN) && !stall;

   // PC / state sequencing with registered error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= BOOT;
         fetch_pc     <= RESET_PC;
         fetch_valid  <= 1'b0;
         jidx         <= '0;
         err_misalign <= 1'b0;
         err_region   <= 1'b0;
`ifdef PC_REDIRECT_DELAY_SLOT_EN
         pending_target <= '0;
`endif
      end else begin
         // Error flags are pulses: cleared every cycle unless re-asserted below.
         err_misalign <= 1'b0;
         err_region   <= 1'b0;
         case (state)
            BOOT: begin
               state       <= RUN;
               fetch_valid <= 1'b1;
            end
            RUN: begin
               if (!stall) begin
                  if (redirect_valid) begin
                     if (bad_align) begin
                        err_misalign <= 1'b1;
                        fetch_pc     <= TRAP_VEC;
                     end else if (bad_region) begin
                        err_region <= 1'b1;
                        fetch_pc   <= TRAP_VEC;
                     end else begin
                        if (redirect_is_j)
                           jidx <= redirect_target[27:2];
`ifdef PC_REDIRECT_DELAY_SLOT_EN
                        pending_target <= redirect_target;
                        fetch_pc       <= fetch_pc + 32'd4;
                        state          <= SLOT;
`else
                        fetch_pc <= redirect_target;
`endif
                     end
                  end else begin
                     fetch_pc <= fetch_pc + 32'd4;
                  end
               end
            end
            SLOT: begin
`ifdef PC_REDIRECT_DELAY_SLOT_EN
               if (!stall) begin
                  fetch_pc <= pending_target;
                  state    <= RUN;
               end
`else
               state <= RUN;
`endif
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed-vector bench for pc_redirect_unit.
// Expectations follow PC_REDIRECT_DELAY_SLOT_EN when it is defined.
module tb_pc_redirect_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic        redirect_ready;
   logic [31:0] redirect_target;
   logic        redirect_is_j;
   logic [31:0] redirect_src_pc;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic [25:0] jidx;
   logic        err_misalign;
   logic        err_region;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   pc_redirect_unit #(
      .RESET_PC(32'h0000_0000),
      .TRAP_VEC(32'h0000_0180)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_ready (redirect_ready),
      .redirect_target(redirect_target),
      .redirect_is_j  (redirect_is_j),
      .redirect_src_pc(redirect_src_pc),
      .fetch_pc       (fetch_pc),
      .fetch_valid    (fetch_valid),
      .jidx           (jidx),
      .err_misalign   (err_misalign),
      .err_region     (err_region)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Advance one clock edge and settle just past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] tgt, input logic [31:0] src, input logic isj);
      redirect_valid  = 1'b1;
      redirect_target = tgt;
      redirect_src_pc = src;
      redirect_is_j   = isj;
   endtask

   task automatic drop();
      redirect_valid = 1'b0;
   endtask

   task automatic check_pc(input string tag, input logic [31:0] exp);
      check(tag, fetch_pc, exp);
   endtask

   task automatic check_err(input string tag, input logic mis, input logic reg_e);
      check({tag, "_mis"}, {31'd0, err_misalign}, {31'd0, mis});
      check({tag, "_reg"}, {31'd0, err_region}, {31'd0, reg_e});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
      redirect_target = '0; redirect_src_pc = '0; redirect_is_j = 1'b0;

      // Reset and free-run
      tick();
      check_pc("rst_pc", 32'h0);
      check("rst_fv", {31'd0, fetch_valid}, 32'd0);
      check("rst_jidx", {6'd0, jidx}, 32'd0);
      check_err("rst", 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      check_pc("boot_pc", 32'h0);
      check("boot_fv", {31'd0, fetch_valid}, 32'd1);
      tick(); check_pc("run4", 32'h4);
      tick(); check_pc("run8", 32'h8);
      tick(); check_pc("runC", 32'hC);
      tick(); check_pc("run10", 32'h10);

      // Valid J-type
      req(32'h0000_0400, 32'h0000_000C, 1'b1);
      #1 check("j_ready", {31'd0, redirect_ready}, 32'd1);
      tick(); drop();
`ifdef PC_REDIRECT_DELAY_SLOT_EN
      check_pc("j_slot", 32'h14);
      check("j_slot_ready", {31'd0, redirect_ready}, 32'd0);
      tick();
`endif
      check_pc("j_tgt", 32'h400);
      check("j_jidx", {6'd0, jidx}, 32'h100);
      check_err("j", 1'b0, 1'b0);
      tick(); check_pc("j_next", 32'h404);

      // Region fault, then the same target as a branch
      req(32'h0000_0100, 32'h0FFF_FFFC, 1'b1);
      tick(); drop();
      check_pc("reg_pc", 32'h180);
      check_err("reg", 1'b0, 1'b1);
      check("reg_jidx", {6'd0, jidx}, 32'h100);
      tick();
      check_err("reg_pulse", 1'b0, 1'b0);
      check_pc("reg_next", 32'h184);
      req(32'h0000_0100, 32'h0FFF_FFFC, 1'b0);
      tick(); drop();
`ifdef PC_REDIRECT_DELAY_SLOT_EN
      check_pc("br_slot", 32'h188);
      tick();
`endif
      check_pc("br_tgt", 32'h100);
      check_err("br", 1'b0, 1'b0);
      check("br_jidx", {6'd0, jidx}, 32'h100);

      // Misalign beats region
      req(32'h2000_0102, 32'h0000_0000, 1'b1);
      tick(); drop();
      check_pc("mis_pc", 32'h180);
      check_err("mis", 1'b1, 1'b0);
      tick();
      check_err("mis_pulse", 1'b0, 1'b0);
      check_pc("mis_next", 32'h184);

      // Stall with held requests
      req(32'h0000_0800, 32'h0000_0184, 1'b0);
`ifdef PC_REDIRECT_DELAY_SLOT_EN
      tick();
      check_pc("st_slot", 32'h188);
      req(32'h0000_0900, 32'h0000_0188, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("st_ready", {31'd0, redirect_ready}, 32'd0);
         tick();
         check_pc("st_hold", 32'h188);
      end
      stall = 1'b0;
      #1 check("st_rel_ready", {31'd0, redirect_ready}, 32'd0);
      tick();
      check_pc("st_tgt", 32'h800);
      check("st_ready2", {31'd0, redirect_ready}, 32'd1);
      tick(); drop();
      check_pc("st_slot2", 32'h804);
      tick();
      check_pc("st_tgt2", 32'h900);
`else
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 check("st_ready", {31'd0, redirect_ready}, 32'd0);
         tick();
         check_pc("st_hold", 32'h184);
      end
      stall = 1'b0;
      #1 check("st_rel_ready", {31'd0, redirect_ready}, 32'd1);
      tick();
      check_pc("st_tgt", 32'h800);
      req(32'h0000_0900, 32'h0000_0800, 1'b0);
      tick(); drop();
      check_pc("st_tgt2", 32'h900);
`endif

      // 32-bit wrap
      req(32'hFFFF_FFF8, 32'h0000_0900, 1'b0);
      tick(); drop();
`ifdef PC_REDIRECT_DELAY_SLOT_EN
      tick();
`endif
      check_pc("wr_f8", 32'hFFFF_FFF8);
      tick(); check_pc("wr_fc", 32'hFFFF_FFFC);
      tick(); check_pc("wr_0", 32'h0);

      // Reset with a redirect in flight
      req(32'h0000_1000, 32'h0000_0000, 1'b1);
      tick(); drop();
`ifdef PC_REDIRECT_DELAY_SLOT_EN
      check_pc("rs_slot", 32'h4);
`else
      check_pc("rs_tgt", 32'h1000);
`endif
      check("rs_jidx_pre", {6'd0, jidx}, 32'h400);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_pc("rs_pc", 32'h0);
      check("rs_fv", {31'd0, fetch_valid}, 32'd0);
      check("rs_jidx", {6'd0, jidx}, 32'd0);
      tick(); check_pc("rs_boot", 32'h0);
      tick(); check_pc("rs_run4", 32'h4);
      tick(); check_pc("rs_run8", 32'h8);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-side PC register and redirect controller. It consumes jump and branch targets built in decode, where a J-type target is {pc_plus4[31:28], instr_index, 2'b00}.
- Performs the reverse of that composition: validates an incoming target against its source PC, then recovers the 26-bit instr_index.
- Sequences the architectural delay slot, then drives the fetch PC to instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0180, PC loaded when a redirect fails validation.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  pipeline stall; freezes PC and FSM.
- redirect_valid  input  1  redirect request from decode/execute.
- redirect_ready  output  1  redirect accepted this cycle when valid&&ready.
- redirect_target  input  32  requested new PC.
- redirect_is_j  input  1  1 = J-type (region-checked), 0 = branch/JR.
- redirect_src_pc  input  32  PC of the jump/branch instruction.
- fetch_pc  output  32  current fetch address.
- fetch_valid  output  1  fetch_pc is a real fetch.
- jidx  output  26  decoded instr_index of last accepted J-type redirect.
- err_misalign  output  1  one-cycle pulse: target[1:0]!=0.
- err_region  output  1  one-cycle pulse: J-type target[31:28]!=(redirect_src_pc+4)[31:28].

Behaviour:
- States: BOOT, RUN, SLOT.
- Reset values:
  - fetch_pc=RESET_PC, fetch_valid=0, jidx=0, err_*=0, state=BOOT.
  - Internal pending_target=0.
- BOOT:
  - Next cycle goes to RUN and sets fetch_valid=1; fetch_pc stays RESET_PC.
  - stall is ignored in BOOT.
- redirect_ready = (state==RUN) && !stall, combinational.
- RUN, stall=1: all registers hold; err_* drop to 0.
- RUN, no accepted redirect: fetch_pc <= fetch_pc+4, 32-bit wrap (32'hFFFF_FFFC -> 32'h0000_0000).
- RUN, accepted redirect, validation in priority order:
  1. target[1:0]!=0 -> err_misalign=1 next cycle; fetch_pc <= TRAP_VEC; state stays RUN; pending not updated.
  2. redirect_is_j && target[31:28]!=(src_pc+4)[31:28] -> err_region=1; fetch_pc <= TRAP_VEC; state RUN.
  3. Otherwise: pending_target <= target; fetch_pc <= fetch_pc+4 (delay slot); state <= SLOT. If redirect_is_j, jidx <= target[27:2]; jidx is unchanged for a branch.
- SLOT:
  - redirect_ready=0; a requester must hold redirect_valid until it is accepted.
  - stall=1 -> hold.
  - Otherwise fetch_pc <= pending_target; state <= RUN.
- Latency: accepted redirect to target on fetch_pc is 2 cycles without stalls (slot PC, then target).
- Error pulses last exactly one cycle. Simultaneous misalign and region faults report only err_misalign.
- Arithmetic: src_pc+4 is computed 32-bit with wrap. If src_pc=32'hFFFF_FFFC, the region is 4'h0.
- Reset mid-SLOT: pending redirect is discarded; state BOOT; fetch_pc=RESET_PC.
- fetch_valid is 0 only in BOOT.

Optional Feature:
- Macro: PC_REDIRECT_DELAY_SLOT_EN.
- Defined: delay-slot sequencing as above; SLOT state exists.
- Undefined:
  - A valid accepted redirect loads fetch_pc <= target directly next cycle, 1-cycle latency.
  - SLOT is never entered; redirect_ready = (state==RUN)&&!stall is unchanged.
  - pending_target is removed.
  - Validation, error and jidx behaviour are unchanged.

Test Plan:
- Reset then free-run: rst 1 cycle, no redirects -> cycle1 fetch_valid=0, pc=0x0; then pc=0x0, 0x4, 0x8, 0xC.
- Valid J-type: at pc=0x0000_0010, redirect target=0x0000_0400, src_pc=0x0000_000C, is_j=1 -> next pc=0x14 (slot), then 0x400; jidx=26'h100; no errors. With macro off: next pc=0x400.
- Region fault: src_pc=0x0FFF_FFFC, target=0x0000_0100, is_j=1 -> err_region pulses 1 cycle, pc=0x180. The same target with is_j=0 is accepted normally.
- Misalign beats region: target=0x2000_0102, is_j=1, src_pc=0x0 -> only err_misalign=1, pc=0x180.
- Stall in SLOT plus held redirect: stall 3 cycles in SLOT -> pc frozen at slot PC, redirect_ready=0. Release stall -> pc=target; a held second request is accepted next RUN cycle.
- Wrap and reset mid-op: pc=0xFFFF_FFFC free-run -> 0x0. Assert rst while in SLOT -> pc=RESET_PC, fetch_valid=0, pending target never fetched.
